// File: rtl/etapa_fetch_pkg.sv
// Shared pipeline package: data width, IF/ID field widths, special
// instruction encodings and the fetch-stage state type.
package etapa_fetch_pkg;

  localparam int NB_DATA   = 32;
  localparam int NB_ADDR   = 8;
  // IF/ID field widths, shared with the ID stage.
  localparam int NB_INSTR  = NB_DATA;
  localparam int NB_PC     = NB_DATA;

  localparam logic [NB_DATA-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [NB_DATA-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  // RUN: fetching normally. HALTED: HALT seen, only reset leaves it.
  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/etapa_fetch_memoria_instrucciones.sv
// Instruction memory: 2^NB_ADDR words, asynchronous read, synchronous write.
// Contents are never cleared by reset; the debug unit loads them.
// Ports:
//   i_clk                          clock
//   i_wr_en / i_wr_addr / i_wr_data write port (debug unit)
//   i_rd_addr / o_rd_data           combinational read port (fetch)
module memoria_instrucciones #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  logic [NB_DATA-1:0] r_mem [2**NB_ADDR];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // A same-cycle write is not visible here until after the edge.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/etapa_fetch.sv
// MIPS instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, fetches from the local instruction memory, honours the
// hazard-unit stall, redirects on taken branches/jumps (flushing the
// wrong-path fetch) and stops fetching after a HALT instruction.
// Ports:
//   i_clk, i_reset (sync, active-low), i_enable (debug run/step)
//   i_stall            hazard-unit stall
//   i_salto/i_dir_salto taken branch/jump and its byte target
//   i_wr_*             instruction-memory write port (debug unit)
//   o_instruccion/o_pc_mas_4  IF/ID register
//   o_halt             sticky halted flag
//   o_pc               current PC (debug readout)
module etapa_fetch
  import etapa_fetch_pkg::*;
#(
  parameter int                                  NB_DATA    = etapa_fetch_pkg::NB_DATA,
  parameter int                                  NB_ADDR    = etapa_fetch_pkg::NB_ADDR,
  parameter logic [etapa_fetch_pkg::NB_DATA-1:0] HALT_INSTR = etapa_fetch_pkg::HALT_INSTR
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_salto,
  input  logic [NB_DATA-1:0] i_dir_salto,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  output logic [NB_DATA-1:0] o_instruccion,
  output logic [NB_DATA-1:0] o_pc_mas_4,
  output logic               o_halt,
  output logic [NB_DATA-1:0] o_pc
);

  localparam logic [NB_DATA-1:0] NOP = NB_DATA'(NOP_INSTR);

  fetch_state_t       r_state, w_state_next;
  logic [NB_DATA-1:0] r_pc, w_pc_next;
  logic [NB_DATA-1:0] r_instr, w_instr_next;
  logic [NB_DATA-1:0] r_pc4, w_pc4_next;
  logic [NB_DATA-1:0] w_fetch;
  logic [NB_DATA-1:0] w_pc_plus4;
  logic               w_unused_dir;

  memoria_instrucciones #(
    .NB_DATA(NB_DATA),
    .NB_ADDR(NB_ADDR)
  ) u_mem (
    .i_clk    (i_clk),
    .i_wr_en  (i_wr_en),
    .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data),
    .i_rd_addr(r_pc[NB_ADDR+1:2]),   // word index; upper PC bits alias
    .o_rd_data(w_fetch)
  );

  assign w_pc_plus4   = r_pc + NB_DATA'(4);   // wraps modulo 2^NB_DATA
  assign w_unused_dir = ^i_dir_salto[1:0];    // targets are word-aligned

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_RUN;
      r_pc    <= '0;
      r_instr <= NOP;
      r_pc4   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_pc4   <= w_pc4_next;
    end
  end

  // Priority: enable/halted, then stall (a stalled branch in ID is not yet
  // valid, so it outranks salto), then redirect, then normal fetch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_pc4_next   = r_pc4;
    if (!i_enable) begin
      // everything holds
    end else if (r_state == S_HALTED) begin
      w_instr_next = NOP;
      w_pc4_next   = '0;
    end else if (i_stall) begin
      // PC and IF/ID hold
    end else if (i_salto) begin
      w_pc_next    = {i_dir_salto[NB_DATA-1:2], 2'b00};
      w_instr_next = NOP;
      w_pc4_next   = '0;
    end else begin
      w_instr_next = w_fetch;
      w_pc4_next   = w_pc_plus4;
      if (w_fetch == HALT_INSTR) w_state_next = S_HALTED;
      else                       w_pc_next    = w_pc_plus4;
    end
  end

  assign o_instruccion = r_instr;
  assign o_pc_mas_4    = r_pc4;
  assign o_halt        = (r_state == S_HALTED);
  assign o_pc          = r_pc;

endmodule

// File: tb/tb_etapa_fetch.sv
module tb_etapa_fetch;

  logic        i_clk = 1'b0;
  logic        i_reset, i_enable, i_stall, i_salto, i_wr_en;
  logic [31:0] i_dir_salto, i_wr_data;
  logic [7:0]  i_wr_addr;
  logic [31:0] o_instruccion, o_pc_mas_4, o_pc;
  logic        o_halt;

  always #5 i_clk = ~i_clk;

  etapa_fetch dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
    .i_salto(i_salto), .i_dir_salto(i_dir_salto), .i_wr_en(i_wr_en),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_instruccion(o_instruccion),
    .o_pc_mas_4(o_pc_mas_4), .o_halt(o_halt), .o_pc(o_pc)
  );

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    logic        stall;
    logic        salto;
    logic [31:0] dir;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_pc;
    logic        e_halt;
  } vec_t;

  vec_t tbl[8];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ei, input logic [31:0] ep4,
                         input logic [31:0] epc, input logic eh);
    chk({tag, " instr"}, o_instruccion, ei);
    chk({tag, " pc4"},   o_pc_mas_4,    ep4);
    chk({tag, " pc"},    o_pc,          epc);
    chk({tag, " halt"},  {31'b0, o_halt}, {31'b0, eh});
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    step();
    i_wr_en = 1'b0;
  endtask

  initial begin
    i_reset = 1'b0; i_enable = 1'b0; i_stall = 1'b0; i_salto = 1'b0;
    i_dir_salto = '0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;

    // load program while held in reset
    wr(8'd0, 32'h11); wr(8'd1, 32'h22); wr(8'd2, 32'h33); wr(8'd3, HALT);
    wr(8'd4, 32'h44); wr(8'd5, 32'h55); wr(8'd6, 32'h66); wr(8'd255, 32'hF0);
    step();
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // run, 2-cycle stall on 0x22 (second with salto too), run into HALT
    tbl[0] = '{0, 0, 32'h0,  32'h11, 32'd4,  32'd4,  0};
    tbl[1] = '{0, 0, 32'h0,  32'h22, 32'd8,  32'd8,  0};
    tbl[2] = '{1, 0, 32'h0,  32'h22, 32'd8,  32'd8,  0};
    tbl[3] = '{1, 1, 32'h40, 32'h22, 32'd8,  32'd8,  0};
    tbl[4] = '{0, 0, 32'h0,  32'h33, 32'd12, 32'd12, 0};
    tbl[5] = '{0, 0, 32'h0,  HALT,   32'd16, 32'd12, 1};
    tbl[6] = '{0, 0, 32'h0,  32'h0,  32'd0,  32'd12, 1};
    tbl[7] = '{0, 1, 32'h40, 32'h0,  32'd0,  32'd12, 1};
    i_reset = 1'b1; i_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_stall = tbl[i].stall; i_salto = tbl[i].salto; i_dir_salto = tbl[i].dir;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_pc4, tbl[i].e_pc, tbl[i].e_halt);
    end
    i_stall = 1'b0; i_salto = 1'b0;

    // redirect at pc=4 to 0x13 -> aligned 0x10
    i_reset = 1'b0; step(); i_reset = 1'b1;
    chk_all("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_all("run0", 32'h11, 32'd4, 32'd4, 1'b0);
    i_salto = 1'b1; i_dir_salto = 32'h0000_0013; step();
    chk_all("salto", 32'h0, 32'h0, 32'h10, 1'b0);
    i_salto = 1'b0; step();
    chk_all("tgt", 32'h44, 32'h14, 32'h14, 1'b0);

    // HALT at PC flushed by a salto
    i_salto = 1'b1; i_dir_salto = 32'hC; step();
    chk_all("toHalt", 32'h0, 32'h0, 32'hC, 1'b0);
    i_dir_salto = 32'h0; step();
    chk_all("flushH", 32'h0, 32'h0, 32'h0, 1'b0);
    i_salto = 1'b0; step();
    chk_all("after", 32'h11, 32'd4, 32'd4, 1'b0);

    // disabled for 3 cycles while mem[5] is rewritten
    i_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr(8'd5, 32'hABCD);
      chk_all($sformatf("frz%0d", i), 32'h11, 32'd4, 32'd4, 1'b0);
    end
    i_enable = 1'b1;
    step(); chk_all("r1", 32'h22, 32'd8,  32'd8,  1'b0);
    step(); chk_all("r2", 32'h33, 32'd12, 32'd12, 1'b0);
    step(); chk_all("r3", HALT,   32'd16, 32'd12, 1'b1);

    // reset mid-halt; memory keeps the debug write
    i_reset = 1'b0; step(); i_reset = 1'b1;
    chk_all("rstH", 32'h0, 32'h0, 32'h0, 1'b0);
    i_salto = 1'b1; i_dir_salto = 32'h14; step();
    chk_all("j14", 32'h0, 32'h0, 32'h14, 1'b0);
    i_salto = 1'b0; step();
    chk_all("mem5", 32'hABCD, 32'h18, 32'h18, 1'b0);

    // write and fetch of the same word in one cycle: old word fetched
    wr(8'd6, 32'h77);
    chk_all("wrold", 32'h66, 32'h1C, 32'h1C, 1'b0);
    i_salto = 1'b1; i_dir_salto = 32'h18; step();
    i_salto = 1'b0; step();
    chk_all("wrnew", 32'h77, 32'h1C, 32'h1C, 1'b0);

    // pc+4 wraps
    i_salto = 1'b1; i_dir_salto = 32'hFFFF_FFFF; step();
    chk_all("jtop", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0);
    i_salto = 1'b0; step();
    chk_all("wrap", 32'hF0, 32'h0, 32'h0, 1'b0);

    // reset mid-stall
    step();
    i_stall = 1'b1; i_reset = 1'b0; step();
    chk_all("rstS", 32'h0, 32'h0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
